// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer
// Sits right after the three-input partial-sum adder. It sums NUM_PASSES
// row-sums into each of OUT_LEN buffer entries. It then requantises each entry
// (right shift, then clamp to DWIDTH) and streams the ofmap row out.
//
// Handshake: a word moves on a rising clk edge when valid and ready are both 1.
// The producer holds data stable while valid=1 and ready=0. All outputs are
// registered. in_ready is 1 only in ACCUM, and out_valid is 1 only in DRAIN.
module psum_accum_buffer #(
    parameter int DWIDTH     = 8,
    parameter int AWIDTH     = 12,
    parameter int OUT_LEN    = 3,
    parameter int NUM_PASSES = 3,
    parameter int SHIFT      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last
);

    localparam int PW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam int SW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [PW-1:0]     POS_LAST  = PW'(OUT_LEN - 1);
    localparam logic [SW-1:0]     PASS_LAST = SW'(NUM_PASSES - 1);
    localparam logic [AWIDTH-1:0] ACC_MAX   = '1;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AWIDTH-1:0] acc_mem [OUT_LEN];
    logic [PW-1:0]     pos;
    logic [PW-1:0]     rd;
    logic [SW-1:0]     pass;

    logic              in_fire;
    logic              out_fire;
    logic              last_in;
    logic [AWIDTH:0]   acc_sum;
    logic [AWIDTH-1:0] acc_new;
    logic [AWIDTH-1:0] first_val;
    logic [PW-1:0]     rd_inc;

    // Requantise: shift right, then clamp to the largest DWIDTH value.
    function automatic logic [DWIDTH-1:0] requant(input logic [AWIDTH-1:0] x);
        logic [AWIDTH-1:0] s;
        s = x >> SHIFT;
        if ((s >> DWIDTH) != '0) return '1;
        return s[DWIDTH-1:0];
    endfunction

    // Accumulate-path and handshake decode.
    always_comb begin
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
        last_in  = in_fire && (pos == POS_LAST) && (pass == PASS_LAST);
        acc_sum  = {1'b0, acc_mem[pos]} + (AWIDTH + 1)'(in_data);
        // The first pass overwrites the entry, so nothing from the last row carries over.
        if (pass == '0)
            acc_new = AWIDTH'(in_data);
        else if (acc_sum[AWIDTH])
            acc_new = ACC_MAX;
        else
            acc_new = acc_sum[AWIDTH-1:0];
        // Entry 0 is written on this same edge only when OUT_LEN=1.
        first_val = (pos == '0) ? acc_new : acc_mem[0];
        rd_inc    = rd + 1'b1;
    end

    // Next-state logic for the ACCUM/DRAIN controller.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (last_in) state_nxt = DRAIN;
            DRAIN:   if (out_fire && out_last) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    // Accumulator storage. It has no reset because pass 0 always overwrites it.
    always_ff @(posedge clk) begin
        if (in_fire) acc_mem[pos] <= acc_new;
    end

    // Counters and registered handshake/output signals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos       <= '0;
            pass      <= '0;
            rd        <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        if (pos == POS_LAST) begin
                            pos <= '0;
                            if (pass == PASS_LAST) pass <= '0;
                            else                   pass <= pass + 1'b1;
                        end else begin
                            pos <= pos + 1'b1;
                        end
                        if (last_in) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= requant(first_val);
                            out_last  <= (OUT_LEN == 1);
                            rd        <= '0;
                        end
                    end
                end
                DRAIN: begin
                    in_ready <= 1'b0;
                    if (out_fire) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rd        <= '0;
                            pos       <= '0;
                            pass      <= '0;
                            in_ready  <= 1'b1;
                        end else begin
                            rd       <= rd_inc;
                            out_data <= requant(acc_mem[rd_inc]);
                            out_last <= (rd_inc == POS_LAST);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Testbench for psum_accum_buffer. Three builds are driven in lockstep from one
// stimulus stream:
//   - the default build;
//   - an AWIDTH=9 build;
//   - a SHIFT=2 build.
// Each build has its own expected queue and monitor.
module tb_psum_accum_buffer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       d_in_ready, d_out_valid, d_out_last;
  logic [7:0] d_out_data;
  logic       a_in_ready, a_out_valid, a_out_last;
  logic [7:0] a_out_data;
  logic       s_in_ready, s_out_valid, s_out_last;
  logic [7:0] s_out_data;

  psum_accum_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data), .out_last(d_out_last)
  );

  psum_accum_buffer #(.AWIDTH(9)) dut_a9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last)
  );

  psum_accum_buffer #(.SHIFT(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_last(s_out_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus frames, pass-major: {p0,p1,p2} of pass 0, then pass 1, then pass 2.
  int frames [4][9] = '{
    '{10, 20, 30, 1, 2, 3, 4, 5, 6},
    '{200, 200, 200, 200, 200, 200, 200, 200, 200},
    '{100, 255, 1, 100, 255, 0, 100, 255, 0},
    '{50, 60, 70, 50, 60, 70, 50, 60, 70}
  };
  // Hand-computed outputs for each build.
  int exp_def [4][3] = '{'{15, 27, 39}, '{255, 255, 255}, '{255, 255, 1}, '{150, 180, 210}};
  int exp_a9  [4][3] = '{'{15, 27, 39}, '{255, 255, 255}, '{255, 255, 1}, '{150, 180, 210}};
  int exp_s2  [4][3] = '{'{3, 6, 9}, '{150, 150, 150}, '{75, 191, 0}, '{37, 45, 52}};

  // Scoreboard queues: each entry is {last, data}.
  logic [8:0] q_def[$];
  logic [8:0] q_a9[$];
  logic [8:0] q_s2[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int f);
    for (int p = 0; p < 3; p++) begin
      q_def.push_back({(p == 2), 8'(exp_def[f][p])});
      q_a9.push_back({(p == 2), 8'(exp_a9[f][p])});
      q_s2.push_back({(p == 2), 8'(exp_s2[f][p])});
    end
  endtask

  // Driver. It is called at a negedge. It presents a word, waits for in_ready,
  // and returns at the negedge that follows the transfer edge.
  task automatic send_word(input int w, output int waited);
    in_valid = 1'b1;
    in_data  = 8'(w);
    waited   = 0;
    while (!d_in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!d_in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: actual 0 required 1");
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int f, output int first_wait);
    int w;
    first_wait = 0;
    for (int i = 0; i < 9; i++) begin
      send_word(frames[f][i], w);
      if (i == 0) first_wait = w;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_def.size() + q_a9.size() + q_s2.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", q_def.size() + q_a9.size() + q_s2.size(), 0);
  endtask

  // Monitors. They sample 2 time units after the negedge, so inputs changed
  // at that negedge have settled. Outputs stay stable until the next posedge.
  always @(negedge clk) begin
    #2;
    if (rst_n && d_out_valid && out_ready) begin
      if (q_def.size() == 0) check("def_unexpected_out", 1, 0);
      else check("def_out", {d_out_last, d_out_data}, q_def.pop_front());
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && a_out_valid && out_ready) begin
      if (q_a9.size() == 0) check("a9_unexpected_out", 1, 0);
      else check("a9_out", {a_out_last, a_out_data}, q_a9.pop_front());
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && s_out_valid && out_ready) begin
      if (q_s2.size() == 0) check("s2_unexpected_out", 1, 0);
      else check("s2_out", {s_out_last, s_out_data}, q_s2.pop_front());
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Directed test sequence
  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", d_in_ready, 0);
    check("rst_out_valid", d_out_valid, 0);
    check("rst_out_data", d_out_data, 0);
    check("rst_out_last", d_out_last, 0);
    rst_n = 1'b1;
    check("in_ready_before_edge", d_in_ready, 0);
    @(negedge clk);
    check("in_ready_after_edge", d_in_ready, 1);

    // Test 1: basic frame, one-cycle latency, out_last only on the final value
    push_exp(0);
    for (int i = 0; i < 8; i++) send_word(frames[0][i], w);
    check("t1_no_valid_before_last", d_out_valid, 0);
    send_word(frames[0][8], w);
    check("t1_valid_after_last", d_out_valid, 1);
    check("t1_in_ready_drain", d_in_ready, 0);
    in_valid = 1'b0;
    wait_idle();

    // Test 2: saturation, both in DWIDTH and, in the AWIDTH=9 build, in AWIDTH
    push_exp(1);
    send_frame(1, w);
    in_valid = 1'b0;
    wait_idle();

    // Test 3: mixed values, which checks SHIFT=2 on position 0 (300>>2=75)
    push_exp(2);
    send_frame(2, w);
    in_valid = 1'b0;
    wait_idle();

    // Test 4: backpressure in DRAIN while in_valid stays high
    out_ready = 1'b0;
    push_exp(0);
    send_frame(0, w);
    in_valid = 1'b1;
    in_data  = 8'(frames[0][0]);
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", d_out_valid, 1);
      check("t4_hold_data", d_out_data, 15);
      check("t4_hold_last", d_out_last, 0);
      check("t4_in_ready_low", d_in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    push_exp(0);
    send_frame(0, w);
    in_valid = 1'b0;
    wait_idle();

    // Test 5: reset in mid-frame after 4 accepted words, then a clean frame
    for (int i = 0; i < 4; i++) send_word(frames[1][i], w);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", d_in_ready, 0);
    check("t5_rst_out_valid", d_out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(0);
    send_frame(0, w);
    in_valid = 1'b0;
    wait_idle();

    // Test 6: two frames back to back, with in_valid and out_ready held high
    push_exp(2);
    push_exp(3);
    send_frame(2, w);
    send_frame(3, w);
    check("t6_second_frame_wait", w, 3);
    in_valid = 1'b0;
    wait_idle();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
